hash_core_arbiter: RTL and testbench
====================================

// Module: hash_core_arbiter
// PURPOSE
//  Shares one 512-bit-block hash core (H_for_HCP2-style start/end handshake) between NREQ requesters,
//  e.g. the HCP challenge parser, commitment and seed-expansion stages of the Picnic-on-SM4 prover/verifier.
//  Round-robin grant, block latched at grant, result returned to the winner with a one-cycle pulse.
//  A watchdog aborts a hung core and reports an error instead of deadlocking the requesters.
// PARAMETERS
//  NREQ     4     number of requesters (2..8)
//  BLK_W    512   message block width fed to the core
//  HASH_W   256   digest width returned by the core
//  TIMEOUT  1023  max cycles in ISSUE waiting for hc_end before abort (counter width = $clog2(TIMEOUT+1))
// PORTS
//  clk         in   1             rising-edge clock
//  reset       in   1             synchronous, active-high
//  req         in   NREQ          level request per requester; held until its resp_valid bit pulses
//  req_block   in   NREQ*BLK_W    block of requester i at [i*BLK_W +: BLK_W]; stable while req[i]=1
//  resp_valid  out  NREQ          one-hot, one-cycle pulse: result for requester i
//  resp_hash   out  HASH_W        digest, valid while resp_valid!=0; holds last value otherwise
//  resp_err    out  1             qualifies resp_valid: 1 = timeout abort, resp_hash meaningless
//  busy        out  1             1 in every state except IDLE
//  grant_id    out  $clog2(NREQ)  index of current/last winner
//  hc_start    out  1             level start to hash core; held until hc_end seen
//  hc_block    out  BLK_W         registered block to hash core; constant while hc_start=1
//  hc_hash     in   HASH_W        core digest, valid when hc_end=1
//  hc_end      in   1             core done (level; stays high until hc_start falls)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, watchdog 0. Reset in any state aborts silently (no resp).
//  States: IDLE -> ISSUE -> RESP -> DRAIN -> IDLE.
//  IDLE: if req!=0, pick first set bit searching ptr, ptr+1, ... (mod NREQ); latch grant_id and
//   hc_block<=req_block[win]; next cycle ISSUE with hc_start=1 (grant-to-start latency 1 cycle).
//  ISSUE: hc_start=1, watchdog++ each cycle. hc_end=1 -> latch resp_hash<=hc_hash, resp_err<=0, go RESP.
//   watchdog==TIMEOUT and hc_end=0 -> resp_err<=1, go RESP. hc_end and timeout same cycle: hc_end wins.
//  RESP (1 cycle): resp_valid[grant_id]=1, hc_start=0, ptr<=grant_id+1 (wraps NREQ-1 -> 0), watchdog<=0.
//  DRAIN: hc_start=0; wait until hc_end=0 (core released) AND req[grant_id]=0; then IDLE.
//   Requester must drop req the cycle after its resp_valid; a requester re-raising req is served only
//   after DRAIN, behind any other pending requesters (fairness).
//  Requests rising during ISSUE/RESP/DRAIN are queued by level only; never preempt the active job.
//  req[i] dropping while i is granted: ignored; job completes and resp pulse is still issued.
//  Minimum throughput: 1 job per (core latency + 4) cycles. resp_valid never has >1 bit set.
//  grant_id width: $clog2(NREQ); ptr arithmetic modulo NREQ, no out-of-range index for non-power-of-2 NREQ.
// STRUCTURE
//  Shared package (hcp_pkg): BLK_W/HASH_W constants, arbiter state enum {IDLE,ISSUE,RESP,DRAIN}.
//  One sub-module: rr_pick (combinational round-robin priority encoder: req, ptr -> win, any).
//  Core instance stays outside; this block only drives/observes the hc_* handshake.
// TESTING
//  1 Single req[2] with block B, core answers after 70 cycles -> hc_start 1 cycle after req, hc_block=B,
//    resp_valid=4'b0100 exactly once, resp_hash=core digest, resp_err=0, busy back to 0 after DRAIN.
//  2 req=4'b1111 held (each drops after own resp) from reset -> grant order 0,1,2,3; resp pulses in that order.
//  3 req[1] re-raised immediately after its resp while req[3] pending -> 3 served before 1.
//  4 Core never asserts hc_end, TIMEOUT=15 -> resp_valid pulses 16 cycles after hc_start rise with
//    resp_err=1; hc_start drops; next request then served normally.
//  5 hc_end rises exactly on cycle watchdog==TIMEOUT -> resp_err=0, digest returned.
//  6 reset asserted mid-ISSUE -> next cycle all outputs 0, no resp pulse; fresh req granted from ptr 0.

Source files
------------

// File: rtl/hash_core_arbiter_pkg.sv
// Shared constants and state encoding for the hash core arbiter.
// Block/digest widths match the single shared 512-bit-block core.
package hash_core_arbiter_pkg;

   localparam int BLK_W  = 512;
   localparam int HASH_W = 256;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP,
      DRAIN
   } arb_state_e;

endpackage

// File: rtl/hash_core_arbiter_if.sv
// Requester and hash-core handshake bundle for the arbiter.
// master = arbiter side, slave = requesters plus core side.
interface hash_core_arbiter_if #(
   parameter int NREQ = 4
);
   import hash_core_arbiter_pkg::*;

   localparam int IW = $clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*BLK_W-1:0] req_block;
   logic [NREQ-1:0]       resp_valid;
   logic [HASH_W-1:0]     resp_hash;
   logic                  resp_err;
   logic                  busy;
   logic [IW-1:0]         grant_id;
   logic                  hc_start;
   logic [BLK_W-1:0]      hc_block;
   logic [HASH_W-1:0]     hc_hash;
   logic                  hc_end;

   modport master (
      input  req, req_block, hc_hash, hc_end,
      output resp_valid, resp_hash, resp_err, busy,
      output grant_id, hc_start, hc_block
   );

   modport slave (
      output req, req_block, hc_hash, hc_end,
      input  resp_valid, resp_hash, resp_err, busy,
      input  grant_id, hc_start, hc_block
   );

endinterface

// File: rtl/hash_core_arbiter_rr_pick.sv
// Round-robin priority encoder: first set req bit at or after ptr.
// Index arithmetic stays below NREQ, so odd NREQ never overflows.
module hash_core_arbiter_rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [$clog2(NREQ)-1:0] win,
   output logic                    any
);

   localparam int IW = $clog2(NREQ);

   int idx;

   // Walk from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      win = '0;
      any = 1'b0;
      idx = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx[IW-1:0]]) begin
            win = idx[IW-1:0];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hash_core_arbiter.sv
// Shares one hash core between NREQ requesters with round-robin grant
// and a watchdog that turns a hung core into an error response.
module hash_core_arbiter
   import hash_core_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1023
) (
   input logic                clk,
   input logic                reset,
   hash_core_arbiter_if.master bus
);

   localparam int IW  = $clog2(NREQ);
   localparam int WDW = $clog2(TIMEOUT + 1);

   arb_state_e        state;
   logic [IW-1:0]     ptr;
   logic [IW-1:0]     win;
   logic              any;
   logic [WDW-1:0]    wd;
   logic [IW-1:0]     grant_id;
   logic [NREQ-1:0]   resp_valid;
   logic [HASH_W-1:0] resp_hash;
   logic              resp_err;
   logic              busy;
   logic              hc_start;
   logic [BLK_W-1:0]  hc_block;

   hash_core_arbiter_rr_pick #(
      .NREQ(NREQ)
   ) u_pick (
      .req (bus.req),
      .ptr (ptr),
      .win (win),
      .any (any)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         wd         <= '0;
         grant_id   <= '0;
         hc_start   <= 1'b0;
         hc_block   <= '0;
         resp_valid <= '0;
         resp_hash  <= '0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         resp_valid <= '0;
         unique case (state)
            IDLE: begin
               if (any) begin
                  grant_id <= win;
                  hc_block <= bus.req_block[int'(win)*BLK_W +: BLK_W];
                  hc_start <= 1'b1;
                  busy     <= 1'b1;
                  wd       <= '0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               // A late hc_end on the timeout cycle still counts as success.
               if (bus.hc_end || wd == WDW'(TIMEOUT)) begin
                  resp_err   <= !bus.hc_end;
                  if (bus.hc_end) resp_hash <= bus.hc_hash;
                  resp_valid <= NREQ'(1) << grant_id;
                  hc_start   <= 1'b0;
                  state      <= RESP;
               end else begin
                  wd <= wd + WDW'(1);
               end
            end
            RESP: begin
               ptr   <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
               wd    <= '0;
               state <= DRAIN;
            end
            DRAIN: begin
               if (!bus.hc_end && !bus.req[grant_id]) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.resp_valid = resp_valid;
   assign bus.resp_hash  = resp_hash;
   assign bus.resp_err   = resp_err;
   assign bus.busy       = busy;
   assign bus.grant_id   = grant_id;
   assign bus.hc_start   = hc_start;
   assign bus.hc_block   = hc_block;

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Directed bench for hash_core_arbiter with a behavioural hash core.
// Core answers after core_lat cycles of hc_start with a simple digest.
module tb_hash_core_arbiter;
   import hash_core_arbiter_pkg::*;

   localparam int N     = 4;
   localparam int TO    = 100;
   localparam int NEVER = 100000;

   typedef struct {
      logic [N-1:0] add;
      int           lat;
      int           exp_idx;
      logic         exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   core_lat = 1;
   int   cnt = 0;
   int   seed = 0;
   logic [BLK_W-1:0] exp_blk [N];
   vec_t vt [9];

   always #5 clk = ~clk;

   hash_core_arbiter_if #(.NREQ(N)) bus ();

   hash_core_arbiter #(
      .NREQ    (N),
      .TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [HASH_W-1:0] dig(input logic [BLK_W-1:0] b);
      return b[HASH_W-1:0] + {b[BLK_W-9:HASH_W], b[BLK_W-1 -: 8]};
   endfunction

   function automatic logic [BLK_W-1:0] mk_blk(input int i, input int s);
      return {{8{32'hC0DE_0000 ^ 32'(s*16 + i)}},
              {8{32'h5A5A_0000 + 32'(i*7 + s)}}};
   endfunction

   // Core model: hc_end is a level held until hc_start falls.
   always @(posedge clk) begin
      if (reset || !bus.hc_start) begin
         cnt        <= 0;
         bus.hc_end <= 1'b0;
      end else if (!bus.hc_end) begin
         cnt <= cnt + 1;
         if (cnt + 1 == core_lat) begin
            bus.hc_end  <= 1'b1;
            bus.hc_hash <= dig(bus.hc_block);
         end
      end
   end

   task automatic chk(input string name,
                      input logic [511:0] act,
                      input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_resp_valid"}, bus.resp_valid, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_hc_start"}, bus.hc_start, 0);
      chk({tag, "_grant_id"}, bus.grant_id, 0);
      chk({tag, "_resp_err"}, bus.resp_err, 0);
      chk({tag, "_resp_hash"}, bus.resp_hash, 0);
      chk({tag, "_hc_block"}, bus.hc_block, 0);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.busy, 0);
   endtask

   task automatic run_job(input logic [N-1:0] add, input int lat,
                          input int ei, input logic ee);
      int n;
      logic idle;
      core_lat = lat;
      seed++;
      for (int i = 0; i < N; i++) begin
         if (add[i]) begin
            exp_blk[i] = mk_blk(i, seed);
            bus.req_block[i*BLK_W +: BLK_W] = exp_blk[i];
         end
      end
      idle = !bus.busy;
      bus.req = bus.req | add;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.hc_start && n < 20);
      if (!bus.hc_start) begin
         chk("hc_start_rise", bus.hc_start, 1);
         return;
      end
      if (idle) chk("start_latency", n, 1);
      chk("grant_id", bus.grant_id, ei);
      chk("hc_block", bus.hc_block, exp_blk[ei]);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.resp_valid == 0 && n < TO + 10);
      chk("resp_valid", bus.resp_valid, N'(1) << ei);
      chk("resp_cycles", n, (lat <= TO) ? lat + 1 : TO + 1);
      chk("resp_err", bus.resp_err, ee);
      if (!ee) chk("resp_hash", bus.resp_hash, dig(exp_blk[ei]));
      chk("hc_start_fall", bus.hc_start, 0);
      bus.req[ei] = 1'b0;
      @(negedge clk);
      chk("resp_single", bus.resp_valid, 0);
      if (bus.req == 0) wait_idle("busy_after_drain");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation ran past its time limit");
      $fatal(1);
   end

   initial begin
      vt[0] = '{4'b1111, 5, 0, 1'b0};
      vt[1] = '{4'b0000, 7, 1, 1'b0};
      vt[2] = '{4'b0000, 3, 2, 1'b0};
      vt[3] = '{4'b0000, 9, 3, 1'b0};
      vt[4] = '{4'b0100, 70, 2, 1'b0};
      vt[5] = '{4'b0001, TO, 0, 1'b0};
      vt[6] = '{4'b0001, TO + 1, 0, 1'b1};
      vt[7] = '{4'b0010, NEVER, 1, 1'b1};
      vt[8] = '{4'b0001, 4, 0, 1'b0};

      bus.req = '0;
      bus.req_block = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 9; v++)
         run_job(vt[v].add, vt[v].lat, vt[v].exp_idx, vt[v].exp_err);

      // Re-raised req[1] must queue behind pending req[3].
      run_job(4'b1010, 6, 1, 1'b0);
      wait_idle("busy_gap");
      run_job(4'b0010, 5, 3, 1'b0);
      run_job(4'b0000, 5, 1, 1'b0);

      // Reset in ISSUE: silent abort, pointer back to 0.
      core_lat = NEVER;
      exp_blk[3] = mk_blk(3, 99);
      bus.req_block[3*BLK_W +: BLK_W] = exp_blk[3];
      bus.req = 4'b1000;
      repeat (3) @(negedge clk);
      chk("pre_reset_start", bus.hc_start, 1);
      chk("pre_reset_grant", bus.grant_id, 3);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("mid_reset");
      reset = 1'b0;
      run_job(4'b0001, 4, 0, 1'b0);
      run_job(4'b0000, 4, 3, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
